input_port_update_arbiter: RTL

- Sits between the input-port cluster of a leaf interface and the single leaf-to-BFT output path.
- Each input port raises a one-cycle freespace_update pulse with its credit/update packet. This block captures the packets into per-port holding registers and coalesces repeated updates from the same port.
- A round-robin scheduler grants one port at a time onto a registered valid/ready output.
- Exposes pending status plus coalesce and stall counters for done-mode debug readout.

---
 rtl/input_port_update_arbiter_pkg.sv | 32 +++
 rtl/input_port_update_arbiter_rr_priority_picker.sv | 51 +++++
 rtl/input_port_update_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/input_port_update_arbiter_pkg.sv
// input_port_update_arbiter_pkg
//   Shared constants for the input-port update arbiter and the saturating
//   adder used by its statistics counters.
//   Contents:
//     PACKET_BITS_DEF   default packet width
//     NUM_IN_PORTS_DEF  default number of requesting input ports
//     NUM_PORT_BITS_DEF default port-index width
//     CNT_BITS_DEF      default statistics counter width
//     sat_inc()         add with saturation at a given counter width (<= 64)
package input_port_update_arbiter_pkg;

  localparam int PACKET_BITS_DEF   = 97;
  localparam int NUM_IN_PORTS_DEF  = 7;
  localparam int NUM_PORT_BITS_DEF = 4;
  localparam int CNT_BITS_DEF      = 32;

  // Counters of any width up to 64 bits share this helper: the caller widens
  // its counter to 64 bits, passes its real width, and truncates the result.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] amount,
                                          input int unsigned bits);
    logic [63:0] max_v;
    logic [64:0] sum;
    max_v = (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    sum   = {1'b0, value} + {1'b0, amount};
    if (sum >= {1'b0, max_v}) begin
      return max_v;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/input_port_update_arbiter_rr_priority_picker.sv
// input_port_update_arbiter_rr_priority_picker
//   Combinational round-robin search: returns the first asserted request at or
//   after ptr, wrapping modulo NUM_IN_PORTS (no power-of-two assumption).
//   Ports:
//     req          in  NUM_IN_PORTS   request vector
//     ptr          in  NUM_PORT_BITS  search start index (< NUM_IN_PORTS)
//     grant_valid  out 1              at least one request asserted
//     grant_idx    out NUM_PORT_BITS  index of the selected request
module input_port_update_arbiter_rr_priority_picker
  import input_port_update_arbiter_pkg::*;
#(
  parameter int NUM_IN_PORTS  = NUM_IN_PORTS_DEF,
  parameter int NUM_PORT_BITS = NUM_PORT_BITS_DEF
) (
  input  logic [NUM_IN_PORTS-1:0]  req,
  input  logic [NUM_PORT_BITS-1:0] ptr,
  output logic                     grant_valid,
  output logic [NUM_PORT_BITS-1:0] grant_idx
);

  logic [2*NUM_IN_PORTS-1:0] req_dbl;
  logic [NUM_IN_PORTS-1:0]   req_rot;
  logic [NUM_PORT_BITS-1:0]  offset;
  logic [NUM_PORT_BITS:0]    idx_sum;
  logic                      found;

  // Doubling the vector turns the wrap-around search into a plain rotate:
  // bit j of req_rot is request (ptr + j) mod NUM_IN_PORTS.
  assign req_dbl = {req, req};
  assign req_rot = NUM_IN_PORTS'(req_dbl >> ptr);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    // Scan downward so the lowest set offset is the one left standing.
    for (int j = NUM_IN_PORTS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found  = 1'b1;
        offset = NUM_PORT_BITS'(j);
      end
    end
    idx_sum = {1'b0, ptr} + {1'b0, offset};
    if (idx_sum >= (NUM_PORT_BITS + 1)'(NUM_IN_PORTS)) begin
      idx_sum = idx_sum - (NUM_PORT_BITS + 1)'(NUM_IN_PORTS);
    end
  end

  assign grant_valid = found;
  assign grant_idx   = idx_sum[NUM_PORT_BITS-1:0];

endmodule

// File: rtl/input_port_update_arbiter.sv
// input_port_update_arbiter
//   Captures one-cycle freespace updates from each input port into holding
//   registers (newer updates overwrite older unsent ones), then grants ports
//   round-robin onto a registered valid/ready output.
//   Ports:
//     clk                      in  1                          clock
//     reset                    in  1                          async, active-low
//     freespace_update         in  NUM_IN_PORTS               per-port strobe
//     packet_from_input_ports  in  PACKET_BITS*NUM_IN_PORTS   per-port packet
//     arb_en                   in  1                          allow new grants
//     clr_cnt                  in  1                          clear counters
//     out_packet               out PACKET_BITS                granted packet
//     out_valid                out 1                          out_packet valid
//     out_ready                in  1                          downstream accept
//     out_port                 out NUM_PORT_BITS              owner of out_packet
//     pending                  out NUM_IN_PORTS               holding reg occupied
//     coalesce_cnt             out CNT_BITS                   overwritten updates
//     stall_cnt                out CNT_BITS                   valid && !ready cycles
module input_port_update_arbiter
  import input_port_update_arbiter_pkg::*;
#(
  parameter int PACKET_BITS   = PACKET_BITS_DEF,
  parameter int NUM_IN_PORTS  = NUM_IN_PORTS_DEF,
  parameter int NUM_PORT_BITS = NUM_PORT_BITS_DEF,
  parameter int CNT_BITS      = CNT_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN_PORTS-1:0]             freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
  input  logic                                arb_en,
  input  logic                                clr_cnt,
  output logic [PACKET_BITS-1:0]              out_packet,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_PORT_BITS-1:0]            out_port,
  output logic [NUM_IN_PORTS-1:0]             pending,
  output logic [CNT_BITS-1:0]                 coalesce_cnt,
  output logic [CNT_BITS-1:0]                 stall_cnt
);

  logic [PACKET_BITS-1:0]   hold_reg [NUM_IN_PORTS];
  logic [PACKET_BITS-1:0]   port_packet [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]  pending_reg;
  logic [PACKET_BITS-1:0]   out_packet_reg;
  logic                     out_valid_reg;
  logic [NUM_PORT_BITS-1:0] out_port_reg;
  logic [NUM_PORT_BITS-1:0] ptr_reg;
  logic [CNT_BITS-1:0]      coalesce_cnt_reg;
  logic [CNT_BITS-1:0]      stall_cnt_reg;

  logic                     pick_valid;
  logic [NUM_PORT_BITS-1:0] pick_idx;
  logic                     out_free;
  logic                     do_grant;
  logic [NUM_IN_PORTS-1:0]  grant_onehot;
  logic [NUM_IN_PORTS-1:0]  coalesce_vec;
  logic [63:0]              coalesce_hits;
  logic [PACKET_BITS-1:0]   grant_packet;
  logic [NUM_PORT_BITS-1:0] ptr_next;
  logic [CNT_BITS-1:0]      coalesce_cnt_next;
  logic [CNT_BITS-1:0]      stall_cnt_next;

  input_port_update_arbiter_rr_priority_picker #(
    .NUM_IN_PORTS (NUM_IN_PORTS),
    .NUM_PORT_BITS(NUM_PORT_BITS)
  ) u_rr_priority_picker (
    .req        (pending_reg),
    .ptr        (ptr_reg),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  assign out_free = !out_valid_reg || out_ready;
  assign do_grant = out_free && arb_en && pick_valid;

  // A strobe on the port being granted this edge is a fresh capture, not an
  // overwrite: the old packet leaves through the output, so nothing is lost.
  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_port
    assign port_packet[gi]  = packet_from_input_ports[gi*PACKET_BITS +: PACKET_BITS];
    assign grant_onehot[gi] = do_grant && (pick_idx == NUM_PORT_BITS'(gi));
    assign coalesce_vec[gi] = freespace_update[gi] && pending_reg[gi] && !grant_onehot[gi];
  end

  always_comb begin
    grant_packet  = '0;
    coalesce_hits = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (grant_onehot[i]) begin
        grant_packet = hold_reg[i];
      end
      coalesce_hits = coalesce_hits + 64'(coalesce_vec[i]);
    end
  end

  assign ptr_next = (pick_idx == NUM_PORT_BITS'(NUM_IN_PORTS - 1)) ? '0
                    : pick_idx + NUM_PORT_BITS'(1);

  assign coalesce_cnt_next = CNT_BITS'(sat_inc(64'(coalesce_cnt_reg), coalesce_hits, CNT_BITS));
  assign stall_cnt_next    = CNT_BITS'(sat_inc(64'(stall_cnt_reg),
                                               64'(out_valid_reg && !out_ready), CNT_BITS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        hold_reg[i] <= '0;
      end
      pending_reg      <= '0;
      out_packet_reg   <= '0;
      out_valid_reg    <= 1'b0;
      out_port_reg     <= '0;
      ptr_reg          <= '0;
      coalesce_cnt_reg <= '0;
      stall_cnt_reg    <= '0;
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (freespace_update[i]) begin
          hold_reg[i]    <= port_packet[i];
          pending_reg[i] <= 1'b1;
        end else if (grant_onehot[i]) begin
          pending_reg[i] <= 1'b0;
        end
      end

      if (do_grant) begin
        out_packet_reg <= grant_packet;
        out_port_reg   <= pick_idx;
        out_valid_reg  <= 1'b1;
        ptr_reg        <= ptr_next;
      end else if (out_free) begin
        out_valid_reg  <= 1'b0;
      end

      if (clr_cnt) begin
        coalesce_cnt_reg <= '0;
        stall_cnt_reg    <= '0;
      end else begin
        coalesce_cnt_reg <= coalesce_cnt_next;
        stall_cnt_reg    <= stall_cnt_next;
      end
    end
  end

  assign out_packet   = out_packet_reg;
  assign out_valid    = out_valid_reg;
  assign out_port     = out_port_reg;
  assign pending      = pending_reg;
  assign coalesce_cnt = coalesce_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;

endmodule
